prio_rr_arbiter: RTL and testbench
==================================

// Module: prio_rr_arbiter
// PURPOSE
//  Parametrised successor to the 8:3 priority encoder. Adds a registered grant, a hold/release
//  handshake, and a runtime-selectable fixed or round-robin priority. Shares one resource among
//  N requesters (bus master select, interrupt dispatch). Outputs the winner as an index and a one-hot.
// PARAMETERS
//  N   8              number of requesters, 2..64, need not be a power of two
//  W   $clog2(N)      localparam; width of the index outputs
// PORTS
//  clk         in   1  single clock; all state updates on the rising edge
//  rst         in   1  asynchronous, active-high reset
//  en          in   1  arbitration enable; 0 blocks new grants and revokes the current grant
//  mode        in   1  0 = fixed priority (highest index wins); 1 = round-robin
//  req         in   N  request vector; bit k = requester k
//  done        in   1  single-cycle pulse from the granted requester to release the grant
//  gnt_valid   out  1  a grant is currently held
//  gnt_idx     out  W  index of the granted requester; 0 when gnt_valid=0
//  gnt_onehot  out  N  one-hot grant; all zeros when gnt_valid=0
//  busy        out  1  equals gnt_valid; kept as a separate port for status-register wiring
// BEHAVIOUR
//  - Reset (asynchronous): state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, busy=0, ptr=N-1.
//  - All outputs are registered. There are no tri-state outputs; the zzz output of the predecessor
//    is replaced by gnt_valid=0.
//  - FSM, two states:
//    - IDLE -> GRANT when en=1 and |req=1.
//      - The winner is registered on that edge, so gnt_valid rises 1 cycle after req is sampled.
//    - GRANT -> IDLE on the first edge where any of the following holds:
//      - done=1;
//      - req[gnt_idx]=0 (requester abandons the grant);
//      - en=0.
//      - On that edge gnt_valid, gnt_idx and gnt_onehot clear.
//    - GRANT holds otherwise. gnt_idx stays stable while gnt_valid=1, whatever other req bits do.
//  - Winner selection, evaluated only in IDLE:
//    - mode=0: highest set index of req wins. ptr is ignored.
//    - mode=1: candidates are searched in the order ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
//      The first set bit wins.
//    - mode is sampled only in IDLE. A change of mode during GRANT takes effect at the next arbitration.
//  - ptr update:
//    - On a release via done or abandon in mode=1: ptr <= (gnt_idx==0) ? N-1 : gnt_idx-1.
//      This makes the last winner lowest priority.
//    - ptr is unchanged in mode=0 and on an en=0 revoke.
//    - ptr wraps modulo N; the value N-1 is used for wrap, not 2^W-1.
//    - ptr only takes values 0..N-1. Since ptr resets to N-1, round-robin starts out matching fixed order.
//  - Simultaneous events:
//    - done together with new requests: return to IDLE, giving exactly one bubble cycle.
//      The next grant appears 2 cycles after done.
//    - done in IDLE is ignored.
//    - done together with en=0 is treated as a revoke, so ptr is unchanged.
//  - req=0 with en=1 in IDLE: stay IDLE, outputs remain 0.
//  - Reset mid-GRANT: grant drops immediately (asynchronous) and ptr returns to N-1.
//  - No combinational path from inputs to outputs.
// STRUCTURE
//  - Package prio_pkg:
//    - state enum {IDLE, GRANT};
//    - localparams MODE_FIXED=1'b0, MODE_RR=1'b1;
//    - function clog2 for tools lacking $clog2.
//  - Sub-module prio_enc_core #(N):
//    - purely combinational;
//    - inputs req, ptr, mode;
//    - outputs win_idx[W-1:0] and any_req;
//    - implements the rotated search (double-width vector, shift by ptr, find highest set bit).
//  - Top level holds the FSM, ptr and the output registers.
// TESTING
//  1. Reset: assert rst with req=8'hFF, en=1
//     -> gnt_valid=0, gnt_idx=0, gnt_onehot=0 for the whole reset; first grant 1 cycle after rst falls.
//  2. Fixed: mode=0, req=8'b1010_0110, en=1
//     -> next cycle gnt_idx=7, gnt_onehot=8'h80;
//     -> after done, req=8'b0010_0110 -> gnt_idx=5.
//  3. Round-robin: mode=1, req=8'hFF held, done pulsed 1 cycle after each grant
//     -> grant sequence 7,6,5,4,3,2,1,0,7 with one IDLE cycle between grants.
//  4. Abandon/revoke:
//     -> granted idx=3, then req[3] drops -> gnt_valid=0 next edge and ptr=2;
//     -> regranted, then en=0 -> gnt_valid=0 next edge and ptr unchanged.
//  5. Non-power-of-2: N=5, mode=1, req=5'b11111 held
//     -> grants 4,3,2,1,0,4; gnt_idx never exceeds 4.
//  6. Reset mid-grant: rst pulsed while gnt_idx=2 in mode=1
//     -> outputs clear asynchronously; next grant is 4 (ptr back at N-1).

Source files
------------

// File: rtl/prio_rr_arbiter_pkg.sv
// prio_pkg: shared types and helpers for the priority / round-robin arbiter.
//   state_t    - arbiter FSM state (IDLE, GRANT)
//   MODE_FIXED - mode value selecting fixed priority (highest index wins)
//   MODE_RR    - mode value selecting round-robin priority
//   clog2()    - ceiling log2, usable in parameter expressions
package prio_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Smallest r with 2**r >= v, never less than 1 so index ports stay at least 1 bit wide.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_core.sv
// prio_enc_core: combinational rotated priority encoder.
//   req     [N-1:0] request vector
//   ptr     [W-1:0] highest-priority position in round-robin mode (0..N-1)
//   mode            MODE_FIXED: highest set index wins; MODE_RR: search ptr, ptr-1, .., 0, N-1, .., ptr+1
//   win_idx [W-1:0] winning index (0 when no request)
//   any_req         at least one request bit set
module prio_enc_core
    import prio_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         mode,
    output logic [W-1:0] win_idx,
    output logic         any_req
);

    logic [W-1:0]   base;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   hit;
    logic [W:0]     sum;

    // Fixed priority is the rotated search with the pointer parked at N-1.
    // After shifting {req,req} right by base+1, rot[N-1] is req[base] and
    // rot[j] is req[(base+1+j) mod N], so the highest set bit of rot is the
    // first hit of the descending circular search.
    always_comb begin
        base = (mode == MODE_RR) ? ptr : W'(N - 1);
        dbl  = {req, req};
        rot  = N'(dbl >> ({1'b0, base} + (W+1)'(1)));
        hit  = '0;
        for (int j = 0; j < N; j++) begin
            if (rot[j]) hit = W'(j);
        end
        sum     = {1'b0, base} + {1'b0, hit} + (W+1)'(1);
        win_idx = W'((sum >= (W+1)'(N)) ? sum - (W+1)'(N) : sum);
        any_req = |req;
    end

endmodule

// File: rtl/prio_rr_arbiter.sv
// prio_rr_arbiter: N-way arbiter with registered grant, hold/release handshake and
// runtime-selectable fixed or round-robin priority.
//   clk, rst        clock; asynchronous active-high reset
//   en              arbitration enable; low blocks new grants and revokes a held grant
//   mode            0 = fixed priority, 1 = round-robin (sampled only when idle)
//   req   [N-1:0]   request vector
//   done            one-cycle release pulse from the granted requester
//   gnt_valid       grant held
//   gnt_idx [W-1:0] granted index (0 when no grant)
//   gnt_onehot[N-1:0] one-hot grant (0 when no grant)
//   busy            mirror of gnt_valid
module prio_rr_arbiter
    import prio_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot,
    output logic         busy
);

    state_t       state, state_n;
    logic [W-1:0] ptr, ptr_n;
    logic         rr_mode, rr_mode_n;
    logic         valid_n;
    logic [W-1:0] idx_n;
    logic [N-1:0] onehot_n;
    logic [W-1:0] win_idx;
    logic         any_req;

    prio_enc_core #(.N(N)) u_enc (
        .req     (req),
        .ptr     (ptr),
        .mode    (mode),
        .win_idx (win_idx),
        .any_req (any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= W'(N - 1);
            rr_mode    <= MODE_FIXED;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            rr_mode    <= rr_mode_n;
            gnt_valid  <= valid_n;
            gnt_idx    <= idx_n;
            gnt_onehot <= onehot_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        rr_mode_n = rr_mode;
        valid_n   = gnt_valid;
        idx_n     = gnt_idx;
        onehot_n  = gnt_onehot;
        case (state)
            IDLE: begin
                if (en && any_req) begin
                    state_n   = GRANT;
                    rr_mode_n = mode;   // mode in force for this grant's release
                    valid_n   = 1'b1;
                    idx_n     = win_idx;
                    onehot_n  = {{(N-1){1'b0}}, 1'b1} << win_idx;
                end
            end
            GRANT: begin
                if (!en || done || !req[gnt_idx]) begin
                    state_n  = IDLE;
                    valid_n  = 1'b0;
                    idx_n    = '0;
                    onehot_n = '0;
                    // A revoke (en low) wins over done and leaves the pointer alone.
                    // Otherwise the last winner drops to lowest round-robin priority.
                    if (en && rr_mode == MODE_RR)
                        ptr_n = (gnt_idx == '0) ? W'(N - 1) : gnt_idx - W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = gnt_valid;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
module tb_prio_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // N = 8 instance
    logic       en_a = 1'b1, mode_a = 1'b0, done_a = 1'b0;
    logic [7:0] req_a = 8'hFF;
    logic       valid_a, busy_a;
    logic [2:0] idx_a;
    logic [7:0] oh_a;

    // N = 5 instance
    logic       en_b = 1'b0, mode_b = 1'b1, done_b = 1'b0;
    logic [4:0] req_b = 5'h00;
    logic       valid_b, busy_b;
    logic [2:0] idx_b;
    logic [4:0] oh_b;

    int total = 0;
    int bad   = 0;

    prio_rr_arbiter #(.N(8)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .req(req_a), .done(done_a),
        .gnt_valid(valid_a), .gnt_idx(idx_a), .gnt_onehot(oh_a), .busy(busy_a)
    );

    prio_rr_arbiter #(.N(5)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .req(req_b), .done(done_b),
        .gnt_valid(valid_b), .gnt_idx(idx_b), .gnt_onehot(oh_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [2:0] idx, input logic [7:0] oh);
        check({tag, "_valid"}, 32'(valid_a), 32'(v));
        check({tag, "_busy"},  32'(busy_a),  32'(v));
        check({tag, "_idx"},   32'(idx_a),   32'(idx));
        check({tag, "_oh"},    32'(oh_a),    32'(oh));
    endtask

    task automatic chk_b(input string tag, input logic v, input logic [2:0] idx, input logic [4:0] oh);
        check({tag, "_valid"}, 32'(valid_b), 32'(v));
        check({tag, "_idx"},   32'(idx_b),   32'(idx));
        check({tag, "_oh"},    32'(oh_b),    32'(oh));
        check({tag, "_range"}, 32'(idx_b <= 3'd4), 32'd1);
    endtask

    int rr8[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int rr5[7] = '{4, 3, 2, 1, 0, 4, 3};
    logic [7:0] one8;
    logic [4:0] one5;

    initial begin
        one8 = 8'd1;
        one5 = 5'd1;

        // 1. Reset held with requests pending: no grant
        #1;
        chk_a("rst0", 1'b0, 3'd0, 8'h00);
        step(); chk_a("rst1", 1'b0, 3'd0, 8'h00);
        step(); chk_a("rst2", 1'b0, 3'd0, 8'h00);
        rst = 1'b0;
        step(); chk_a("rst_first", 1'b1, 3'd7, 8'h80);
        req_a = 8'h00;
        step(); chk_a("abandon_fixed", 1'b0, 3'd0, 8'h00);

        // 2. Fixed priority
        req_a = 8'b1010_0110;
        step(); chk_a("fix_a6", 1'b1, 3'd7, 8'h80);
        req_a = 8'b1111_1111;
        step(); chk_a("fix_hold", 1'b1, 3'd7, 8'h80);      // stable while other bits change
        done_a = 1'b1; req_a = 8'b0010_0110;
        step(); chk_a("fix_done", 1'b0, 3'd0, 8'h00);
        done_a = 1'b0;
        step(); chk_a("fix_26", 1'b1, 3'd5, 8'h20);
        req_a = 8'h00; done_a = 1'b1;
        step(); chk_a("fix_rel", 1'b0, 3'd0, 8'h00);
        step(); chk_a("done_idle", 1'b0, 3'd0, 8'h00);     // done in IDLE ignored
        done_a = 1'b0; req_a = 8'h00;
        step(); chk_a("idle_noreq", 1'b0, 3'd0, 8'h00);

        // 3. Round-robin, ptr still N-1 (fixed-mode releases leave it alone)
        mode_a = 1'b1; req_a = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step(); chk_a($sformatf("rr8_g%0d", k), 1'b1, 3'(rr8[k]), one8 << rr8[k]);
            done_a = 1'b1;
            step(); chk_a($sformatf("rr8_b%0d", k), 1'b0, 3'd0, 8'h00);
            done_a = 1'b0;
        end
        // ptr now 6

        // 4. Abandon then revoke
        req_a = 8'b0000_1000;
        step(); chk_a("ab_g3", 1'b1, 3'd3, 8'h08);
        req_a = 8'b1111_0111;
        step(); chk_a("ab_drop", 1'b0, 3'd0, 8'h00);
        step(); chk_a("ab_ptr2", 1'b1, 3'd2, 8'h04);       // search starts at ptr=2
        en_a = 1'b0;
        step(); chk_a("rv_drop", 1'b0, 3'd0, 8'h00);
        en_a = 1'b1; req_a = 8'hFF;
        step(); chk_a("rv_ptr2", 1'b1, 3'd2, 8'h04);       // ptr unchanged by revoke
        en_a = 1'b0; done_a = 1'b1;
        step(); chk_a("rvd_drop", 1'b0, 3'd0, 8'h00);
        en_a = 1'b1; done_a = 1'b0;
        step(); chk_a("rvd_ptr2", 1'b1, 3'd2, 8'h04);      // done+en=0 is a revoke
        en_a = 1'b0; req_a = 8'h00;

        // 5. N=5 round-robin
        en_b = 1'b1; mode_b = 1'b1; req_b = 5'b11111;
        for (int k = 0; k < 7; k++) begin
            step(); chk_b($sformatf("rr5_g%0d", k), 1'b1, 3'(rr5[k]), one5 << rr5[k]);
            done_b = 1'b1;
            step(); chk_b($sformatf("rr5_b%0d", k), 1'b0, 3'd0, 5'h00);
            done_b = 1'b0;
        end
        step(); chk_b("rr5_g2", 1'b1, 3'd2, 5'h04);

        // 6. Asynchronous reset mid-grant
        #2 rst = 1'b1;
        #1 chk_b("arst", 1'b0, 3'd0, 5'h00);
        #1 rst = 1'b0;
        step(); chk_b("arst_next", 1'b1, 3'd4, 5'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
